// File: rtl/ts_packet_arbiter.sv
// Two-source MPEG-TS packet arbiter with null-packet insertion.
// Owns the output byte stream packet-by-packet; fills idle slots with null packets.
module ts_packet_arbiter #(
  parameter int          PKT_LEN  = 188,
  parameter logic [12:0] NULL_PID = 13'h1FFF
) (
  input  logic        i_clk_in,
  input  logic        i_rst,
  input  logic        i_slot,
  input  logic [7:0]  i_a_data,
  input  logic        i_a_valid,
  input  logic        i_a_psync,
  output logic        o_a_ready,
  input  logic [7:0]  i_b_data,
  input  logic        i_b_valid,
  input  logic        i_b_psync,
  output logic        o_b_ready,
  output logic [7:0]  o_data,
  output logic        o_dvalid,
  output logic        o_psync,
  output logic [1:0]  o_grant,
  output logic        o_err,
  output logic [15:0] o_null_cnt
);

  // state | meaning
  // ARB   | waiting for a packet start from A or B, else start a null packet
  // XFER_A| forwarding a packet from source A
  // XFER_B| forwarding a packet from source B
  // NULL  | emitting an inserted null packet
  localparam logic [1:0] S_ARB    = 2'b00;
  localparam logic [1:0] S_XFER_A = 2'b01;
  localparam logic [1:0] S_XFER_B = 2'b10;
  localparam logic [1:0] S_NULL   = 2'b11;

  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_bcnt;
  logic        r_last_b;
  logic [7:0]  r_data;
  logic        r_dvalid;
  logic        r_psync;
  logic        r_err;
  logic [15:0] r_null_cnt;

  logic        w_req_a;
  logic        w_req_b;
  logic        w_pick_a;
  logic        w_pick_b;
  logic        w_flush_a;
  logic        w_flush_b;
  logic        w_emit;
  logic [7:0]  w_emit_data;
  logic        w_emit_psync;
  logic        w_err;
  logic        w_null_start;
  logic [1:0]  w_next_state;
  logic [7:0]  w_next_bcnt;
  logic [7:0]  w_null_byte;
  logic        w_last;

  assign w_req_a  = i_a_valid & i_a_psync;
  assign w_req_b  = i_b_valid & i_b_psync;
  // on a tie the source not granted last wins
  assign w_pick_b = w_req_b & (~w_req_a | ~r_last_b);
  assign w_pick_a = w_req_a & ~w_pick_b;
  // with nobody requesting, mid-packet garbage is drained one byte per slot
  assign w_flush_a = ~w_req_a & ~w_req_b & i_a_valid;
  assign w_flush_b = ~w_req_a & ~w_req_b & i_b_valid & ~i_a_valid;
  assign w_last    = (r_bcnt == LAST_BYTE);

  always_comb begin
    unique case (r_bcnt)
      8'd1:    w_null_byte = {3'b000, NULL_PID[12:8]};
      8'd2:    w_null_byte = NULL_PID[7:0];
      8'd3:    w_null_byte = 8'h10;
      default: w_null_byte = 8'hFF;
    endcase
  end

  always_comb begin
    o_a_ready    = 1'b0;
    o_b_ready    = 1'b0;
    w_emit       = 1'b0;
    w_emit_data  = 8'h00;
    w_emit_psync = 1'b0;
    w_err        = 1'b0;
    w_null_start = 1'b0;
    w_next_state = r_state;
    w_next_bcnt  = r_bcnt;
    if (i_slot) begin
      case (r_state)
        S_ARB: begin
          w_emit       = 1'b1;
          w_emit_psync = 1'b1;
          w_next_bcnt  = 8'd1;
          if (w_pick_a) begin
            o_a_ready    = 1'b1;
            w_emit_data  = i_a_data;
            w_next_state = S_XFER_A;
          end else if (w_pick_b) begin
            o_b_ready    = 1'b1;
            w_emit_data  = i_b_data;
            w_next_state = S_XFER_B;
          end else begin
            o_a_ready    = w_flush_a;
            o_b_ready    = w_flush_b;
            w_emit_data  = 8'h47;
            w_null_start = 1'b1;
            w_next_state = S_NULL;
          end
        end
        S_XFER_A: begin
          o_a_ready = 1'b1;
          if (i_a_valid) begin
            w_emit      = 1'b1;
            w_emit_data = i_a_data;
            w_err       = i_a_psync;
          end
        end
        S_XFER_B: begin
          o_b_ready = 1'b1;
          if (i_b_valid) begin
            w_emit      = 1'b1;
            w_emit_data = i_b_data;
            w_err       = i_b_psync;
          end
        end
        default: begin
          w_emit      = 1'b1;
          w_emit_data = w_null_byte;
        end
      endcase
      if (r_state != S_ARB && w_emit) begin
        if (w_last) begin
          w_next_state = S_ARB;
          w_next_bcnt  = 8'd0;
        end else begin
          w_next_bcnt  = r_bcnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state    <= S_ARB;
      r_bcnt     <= 8'd0;
      r_last_b   <= 1'b1;
      r_data     <= 8'h00;
      r_dvalid   <= 1'b0;
      r_psync    <= 1'b0;
      r_err      <= 1'b0;
      r_null_cnt <= 16'd0;
    end else begin
      r_state  <= w_next_state;
      r_bcnt   <= w_next_bcnt;
      r_dvalid <= w_emit;
      r_psync  <= w_emit_psync;
      r_err    <= w_err;
      if (w_emit)
        r_data <= w_emit_data;
      if (w_null_start)
        r_null_cnt <= r_null_cnt + 16'd1;
      if (i_slot && r_state == S_ARB && (w_pick_a || w_pick_b))
        r_last_b <= w_pick_b;
    end
  end

  assign o_data     = r_data;
  assign o_dvalid   = r_dvalid;
  assign o_psync    = r_psync;
  assign o_grant    = r_state;
  assign o_err      = r_err;
  assign o_null_cnt = r_null_cnt;

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Directed bench for ts_packet_arbiter: behavioural sources drive packets,
// captured output stream is compared against hand-built expected streams.
module tb_ts_packet_arbiter;

  logic        clk = 1'b0;
  logic        i_rst, i_slot;
  logic [7:0]  i_a_data, i_b_data;
  logic        i_a_valid, i_a_psync, i_b_valid, i_b_psync;
  logic        o_a_ready, o_b_ready;
  logic [7:0]  o_data;
  logic        o_dvalid, o_psync, o_err;
  logic [1:0]  o_grant;
  logic [15:0] o_null_cnt;

  always #5 clk = ~clk;

  ts_packet_arbiter dut (
    .i_clk_in   (clk),
    .i_rst      (i_rst),
    .i_slot     (i_slot),
    .i_a_data   (i_a_data),
    .i_a_valid  (i_a_valid),
    .i_a_psync  (i_a_psync),
    .o_a_ready  (o_a_ready),
    .i_b_data   (i_b_data),
    .i_b_valid  (i_b_valid),
    .i_b_psync  (i_b_psync),
    .o_b_ready  (o_b_ready),
    .o_data     (o_data),
    .o_dvalid   (o_dvalid),
    .o_psync    (o_psync),
    .o_grant    (o_grant),
    .o_err      (o_err),
    .o_null_cnt (o_null_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // source models
  bit a_en, b_en;
  int a_pkt, a_idx, b_pkt, b_idx;
  int a_stall_at, a_stall_left, a_inj_at;
  int b_acc, gaps, err_pulses, err_at, bad_ready;
  logic [7:0] cap_data[$], exp_data[$];
  bit         cap_psync[$], exp_psync[$];

  function automatic logic [7:0] src_byte(input bit b, input int pkt, input int idx);
    if (idx == 0) return 8'h47;
    return b ? (8'hA0 ^ 8'(pkt * 5 + idx)) : 8'(pkt * 3 + idx);
  endfunction

  function automatic logic [7:0] null_byte(input int idx);
    case (idx)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic push_pkt(input bit b, input int pkt);
    for (int i = 0; i < 188; i++) begin
      exp_data.push_back(src_byte(b, pkt, i));
      exp_psync.push_back(i == 0);
    end
  endtask

  task automatic push_null();
    for (int i = 0; i < 188; i++) begin
      exp_data.push_back(null_byte(i));
      exp_psync.push_back(i == 0);
    end
  endtask

  task automatic compare_stream(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_len"}, cap_data.size(), exp_data.size());
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
      if (cap_data[i] !== exp_data[i] || cap_psync[i] !== exp_psync[i]) mism++;
    chk({tag, "_bytes"}, mism, 0);
  endtask

  task automatic clear_model();
    a_en = 0; b_en = 0;
    a_pkt = 0; a_idx = 0; b_pkt = 0; b_idx = 0;
    a_stall_at = -1; a_stall_left = 0; a_inj_at = -1;
    b_acc = 0; gaps = 0; err_pulses = 0; err_at = -1;
    cap_data.delete(); cap_psync.delete(); exp_data.delete(); exp_psync.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1; i_slot = 0; i_a_valid = 0; i_b_valid = 0;
    i_a_psync = 0; i_b_psync = 0; i_a_data = 0; i_b_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 0;
    clear_model();
  endtask

  task automatic step(input bit slot);
    bit va, vb, acc_a, acc_b;
    @(negedge clk);
    i_slot = slot;
    va = a_en;
    if (a_en && a_idx == a_stall_at && a_stall_left > 0) begin
      va = 0;
      a_stall_left--;
    end
    vb = b_en;
    i_a_valid = va;
    i_a_data  = src_byte(0, a_pkt, a_idx);
    i_a_psync = (a_idx == 0) || (a_idx == a_inj_at);
    i_b_valid = vb;
    i_b_data  = src_byte(1, b_pkt, b_idx);
    i_b_psync = (b_idx == 0);
    #1;
    acc_a = va && o_a_ready;
    acc_b = vb && o_b_ready;
    if ((o_a_ready && o_b_ready) || (!slot && (o_a_ready || o_b_ready))) bad_ready++;
    @(posedge clk);
    #1;
    if (o_dvalid) begin
      cap_data.push_back(o_data);
      cap_psync.push_back(o_psync);
    end else begin
      gaps++;
      if (o_psync) bad_ready++;
    end
    if (o_err) begin
      err_pulses++;
      err_at = cap_data.size() - 1;
    end
    if (acc_a) begin
      a_idx++;
      if (a_idx == 188) begin a_idx = 0; a_pkt++; end
    end
    if (acc_b) begin
      b_acc++;
      b_idx++;
      if (b_idx == 188) begin b_idx = 0; b_pkt++; end
    end
  endtask

  initial begin
    bad_ready = 0;
    i_rst = 1;
    clear_model();
    do_reset();

    // reset state
    #1;
    chk("rst_dvalid", o_dvalid, 0);
    chk("rst_psync", o_psync, 0);
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_nullcnt", o_null_cnt, 0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_err", o_err, 0);

    // idle slots freeze everything
    repeat (3) step(0);
    chk("freeze_gaps", gaps, 3);
    chk("freeze_grant", o_grant, 2'b00);
    chk("freeze_nullcnt", o_null_cnt, 0);

    // continuous null packets
    gaps = 0;
    step(1);
    chk("null_first_grant", o_grant, 2'b11);
    chk("null_first_cnt", o_null_cnt, 1);
    repeat (375) step(1);
    push_null(); push_null();
    compare_stream("null");
    chk("null_byte1", cap_data[1], 8'h1F);
    chk("null_cnt2", o_null_cnt, 2);
    chk("null_grant_end", o_grant, 2'b00);

    // A and B both continuous: alternate A, B, A, B
    do_reset();
    a_en = 1; b_en = 1;
    step(1);
    chk("alt_first_grant", o_grant, 2'b01);
    repeat (751) step(1);
    push_pkt(0, 0); push_pkt(1, 0); push_pkt(0, 1); push_pkt(1, 1);
    compare_stream("alt");
    chk("alt_gaps", gaps, 0);
    chk("alt_nullcnt", o_null_cnt, 0);

    // A stalls 5 slots at byte 100
    do_reset();
    a_en = 1; a_stall_at = 100; a_stall_left = 5;
    repeat (193) step(1);
    push_pkt(0, 0);
    compare_stream("stall");
    chk("stall_gaps", gaps, 5);
    chk("stall_grant_end", o_grant, 2'b00);

    // B mid-packet while arbitrating: flushed, nulls inserted
    do_reset();
    b_en = 1; b_idx = 185;
    step(1);
    chk("flush_first_acc", b_acc, 1);
    chk("flush_first_grant", o_grant, 2'b11);
    repeat (3 * 188 - 1) step(1);
    push_null(); push_null(); push_null();
    compare_stream("flush");
    chk("flush_acc", b_acc, 3);
    chk("flush_nullcnt", o_null_cnt, 3);
    step(1);
    chk("flush_then_b", o_grant, 2'b10);
    chk("flush_then_psync", o_psync, 1);

    // A asserts PSYNC on byte 50
    do_reset();
    a_en = 1; a_inj_at = 50;
    repeat (188) step(1);
    push_pkt(0, 0);
    compare_stream("perr");
    chk("perr_pulses", err_pulses, 1);
    chk("perr_at", err_at, 50);
    a_inj_at = -1;
    step(1);
    chk("perr_next_grant", o_grant, 2'b01);
    chk("perr_next_psync", o_psync, 1);

    // reset at BCNT=90 of a B packet
    do_reset();
    a_en = 1; b_en = 1;
    repeat (278) step(1);
    chk("mid_cap", cap_data.size(), 278);
    chk("mid_grant", o_grant, 2'b10);
    @(negedge clk);
    i_rst = 1; i_slot = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_dvalid", o_dvalid, 0);
    chk("mid_rst_grant", o_grant, 2'b00);
    chk("mid_rst_nullcnt", o_null_cnt, 0);
    @(negedge clk);
    i_rst = 0;
    step(1);
    chk("mid_after_grant", o_grant, 2'b01);
    chk("mid_after_data", o_data, 8'h47);
    chk("mid_after_psync", o_psync, 1);

    chk("ready_rules", bad_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
